// File: rtl/pixel_proc_pkg.sv
// Shared types and constants for the pixel stream processor.
package pixel_proc_pkg;

    // Processing mode, latched at frame start
    typedef enum logic [1:0] {
        MODE_BYPASS = 2'b00,
        MODE_INVERT = 2'b01,
        MODE_GAUSS  = 2'b10,
        MODE_THRESH = 2'b11
    } mode_e;

    // Frame sequencing states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Gaussian kernel weights sum to 16, so the normalising shift is 4
    localparam int GAUSS_SHIFT = 4;

    // Pointwise modes emit one output per accepted input pixel
    function automatic logic is_pointwise(input mode_e m);
        return (m != MODE_GAUSS);
    endfunction

endpackage

// File: rtl/pixel_stream_proc_line_buffer.sv
// One-row pixel delay. The top addresses it with the current column, so
// the word read before the write is the pixel from the same column one row up.
// Contents are deliberately not reset.
module line_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Overwrite the old row entry with the new pixel on each accepted input
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/pixel_stream_proc.sv
// Frame-based pixel processor: bypass, invert, 3x3 Gaussian and threshold,
// with a single registered output stage that honours backpressure.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; latches mode/thresh and clears counters
// ST_RUN   | accepting IMG_W*IMG_H pixels in raster order
// ST_DRAIN | input closed; waits for the last output to be taken, then done
module pixel_stream_proc
    import pixel_proc_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] thresh,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int SW = DATA_W + 4;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    state_e            state;
    mode_e             mode_q;
    logic [DATA_W-1:0] thresh_q;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;

    logic              accept;
    logic              last_px;
    logic              produce;

    logic [DATA_W-1:0] lb1_q;
    logic [DATA_W-1:0] lb2_q;
    logic [DATA_W-1:0] top_w [2];
    logic [DATA_W-1:0] mid_w [2];
    logic [DATA_W-1:0] bot_w [2];
    logic [SW-1:0]     gsum;
    logic [DATA_W-1:0] pix_out;

    // Single output register: input may advance whenever that register is free or being drained
    assign s_ready = (state == ST_RUN) && (!m_valid || m_ready);
    assign accept  = s_valid && s_ready;
    assign last_px = (row == ROW_LAST) && (col == COL_LAST);
    // Gaussian output needs two full rows and two columns of history
    assign produce = is_pointwise(mode_q) || ((row >= RW'(2)) && (col >= CW'(2)));

    // lb1 yields the pixel from row-1, lb2 the pixel from row-2, same column
    line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb_row1 (
        .clk   (clk),
        .we    (accept),
        .addr  (col),
        .wdata (s_data),
        .rdata (lb1_q)
    );

    line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb_row2 (
        .clk   (clk),
        .we    (accept),
        .addr  (col),
        .wdata (lb1_q),
        .rdata (lb2_q)
    );

    // Keep the two previous columns of the 3-row window; the third column is the live input
    always_ff @(posedge clk) begin
        if (accept) begin
            top_w[0] <= top_w[1];
            top_w[1] <= lb2_q;
            mid_w[0] <= mid_w[1];
            mid_w[1] <= lb1_q;
            bot_w[0] <= bot_w[1];
            bot_w[1] <= s_data;
        end
    end

    // Kernel [1 2 1; 2 4 2; 1 2 1] centred on (row-1, col-1)
    always_comb begin
        gsum = SW'(top_w[0])         + (SW'(top_w[1]) << 1) + SW'(lb2_q)
             + (SW'(mid_w[0]) << 1)  + (SW'(mid_w[1]) << 2) + (SW'(lb1_q) << 1)
             + SW'(bot_w[0])         + (SW'(bot_w[1]) << 1) + SW'(s_data);
    end

    // Select the processed value for the pixel being accepted
    always_comb begin
        pix_out = s_data;
        case (mode_q)
            MODE_BYPASS: pix_out = s_data;
            MODE_INVERT: pix_out = ~s_data;
            MODE_GAUSS:  pix_out = gsum[GAUSS_SHIFT +: DATA_W];
            MODE_THRESH: pix_out = (s_data >= thresh_q) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
            default:     pix_out = s_data;
        endcase
    end

    // Frame sequencing, raster counters and the registered output stage
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            mode_q   <= MODE_BYPASS;
            thresh_q <= '0;
            row      <= '0;
            col      <= '0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_last   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mode_q   <= mode_e'(mode);
                        thresh_q <= thresh;
                        row      <= '0;
                        col      <= '0;
                        busy     <= 1'b1;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        if (col == COL_LAST) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                        if (last_px) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Empty now, or the final pixel is handed off this cycle
                    if (!m_valid || m_ready) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (accept && produce) begin
                m_valid <= 1'b1;
                m_data  <= pix_out;
                m_last  <= last_px;
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pixel_stream_proc.sv
// Self-checking bench for pixel_stream_proc: table of frame tests checked
// against an image-level reference model, plus hand sequences for latency,
// backpressure hold, reload and mid-frame reset.
module tb_pixel_stream_proc;
    import pixel_proc_pkg::*;

    localparam int W    = 32;
    localparam int H    = 32;
    localparam int NPIX = W * H;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic [1:0] mode;
    logic [7:0] thresh;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_last;
    logic       busy;
    logic       done;

    pixel_stream_proc #(.DATA_W(8), .IMG_W(W), .IMG_H(H)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .start   (start),
        .mode    (mode),
        .thresh  (thresh),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] md;
        logic [7:0] thr;
        int         pat;      // 0 ramp, 1 const 0x40, 2 impulse, 3 random
        int         rdy;      // 1 always ready, 2 random ready and input gaps
        int         exp_cnt;
        int         ia; int va;
        int         ib; int vb;
        int         ic; int vc;
    } vec_t;

    vec_t       vecs [9];
    int         img [H][W];
    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];
    bit         got_last [$];
    int         done_cnt;
    int         stab_err;
    logic       prev_stall;
    logic [7:0] prev_data;
    logic       prev_last;
    int         ready_mode;
    int         errors = 0;
    int         checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic edge_drive();
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic sample();
        @(negedge clk);
        if (!resetn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last))
                stab_err++;
            if (m_valid && m_ready) begin
                got_q.push_back(m_data);
                got_last.push_back(m_last);
            end
            if (done) done_cnt++;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    endtask

    task automatic fill_img(input int pat);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                case (pat)
                    0:       img[r][c] = (r * W + c) % 256;
                    1:       img[r][c] = 64;
                    2:       img[r][c] = (r == 5 && c == 5) ? 255 : 0;
                    default: img[r][c] = int'($urandom_range(0, 255));
                endcase
    endtask

    // Reference: whole-image arithmetic, outputs in raster order of their centres
    task automatic build_expected(input logic [1:0] md, input logic [7:0] thr);
        int s;
        int p;
        exp_q.delete();
        if (md == MODE_GAUSS) begin
            for (int r = 1; r < H - 1; r++)
                for (int c = 1; c < W - 1; c++) begin
                    s = 0;
                    for (int dr = -1; dr <= 1; dr++)
                        for (int dc = -1; dc <= 1; dc++)
                            s += img[r + dr][c + dc] * ((dr == 0) ? 2 : 1) * ((dc == 0) ? 2 : 1);
                    exp_q.push_back(8'(s / 16));
                end
        end else begin
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++) begin
                    p = img[r][c];
                    case (md)
                        MODE_BYPASS: exp_q.push_back(8'(p));
                        MODE_INVERT: exp_q.push_back(8'(255 - p));
                        default:     exp_q.push_back((p >= int'(thr)) ? 8'hFF : 8'h00);
                    endcase
                end
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data",  m_data,  0);
        chk("rst_m_last",  m_last,  0);
        chk("rst_busy",    busy,    0);
        chk("rst_done",    done,    0);
    endtask

    task automatic run_frame(input logic [1:0] md, input logic [7:0] thr, input int rdy);
        int idx;
        int cyc;
        int ones;
        int mism;
        got_q.delete();
        got_last.delete();
        done_cnt   = 0;
        stab_err   = 0;
        prev_stall = 1'b0;
        ready_mode = rdy;
        edge_drive();
        mode = md; thresh = thr; start = 1'b1;
        sample();
        edge_drive();
        start = 1'b0; mode = ~md; thresh = ~thr;
        sample();
        chk("busy_rise", busy, 1);
        idx = 0;
        cyc = 0;
        while (idx < NPIX && cyc < 20000) begin
            edge_drive();
            s_valid = (rdy == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_data  = 8'(img[idx / W][idx % W]);
            sample();
            if (s_valid && s_ready) idx++;
            cyc++;
        end
        chk("all_accepted", idx, NPIX);
        cyc = 0;
        while (done_cnt == 0 && cyc < 200) begin
            edge_drive();
            s_valid = 1'b0;
            sample();
            cyc++;
        end
        chk("done_seen", done_cnt, 1);
        chk("busy_fall", busy, 0);
        repeat (3) begin
            edge_drive();
            sample();
        end
        chk("done_single", done_cnt, 1);
        chk("out_count", got_q.size(), exp_q.size());
        mism = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) mism++;
        chk("content_mismatches", mism, 0);
        ones = 0;
        foreach (got_last[i]) if (got_last[i]) ones++;
        chk("last_count", ones, 1);
        chk("last_position", (got_last.size() > 0) ? 32'(got_last[got_last.size() - 1]) : 0, 1);
        chk("stable_under_stall", stab_err, 0);
    endtask

    initial begin
        int idx;
        int cyc;
        vecs[0] = '{MODE_BYPASS, 8'h00, 0, 1, 1024, 300, 'h2C, 1023, 'hFF, 0,    'h00};
        vecs[1] = '{MODE_INVERT, 8'h00, 0, 1, 1024, 5,   'hFA, 256,  'hFF, 1023, 'h00};
        vecs[2] = '{MODE_THRESH, 8'h80, 0, 1, 1024, 127, 'h00, 128,  'hFF, 1023, 'hFF};
        vecs[3] = '{MODE_GAUSS,  8'h00, 1, 1, 900,  0,   'h40, 899,  'h40, 450,  'h40};
        vecs[4] = '{MODE_GAUSS,  8'h00, 2, 1, 900,  124, 'h3F, 123,  'h1F, 93,   'h0F};
        vecs[5] = '{MODE_BYPASS, 8'h00, 0, 2, 1024, 300, 'h2C, 1023, 'hFF, 0,    'h00};
        vecs[6] = '{MODE_GAUSS,  8'h00, 3, 2, 900,  -1, 0, -1, 0, -1, 0};
        vecs[7] = '{MODE_THRESH, 8'($urandom_range(1, 254)), 3, 2, 1024, -1, 0, -1, 0, -1, 0};
        vecs[8] = '{MODE_INVERT, 8'h00, 3, 2, 1024, -1, 0, -1, 0, -1, 0};

        resetn = 1'b0; start = 1'b0; mode = 2'b00; thresh = 8'h00;
        s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b1; ready_mode = 1;
        prev_stall = 1'b0; done_cnt = 0; stab_err = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        edge_drive();
        resetn = 1'b1;
        sample();

        for (int v = 0; v < 9; v++) begin
            fill_img(vecs[v].pat);
            build_expected(vecs[v].md, vecs[v].thr);
            run_frame(vecs[v].md, vecs[v].thr, vecs[v].rdy);
            chk("table_count", got_q.size(), vecs[v].exp_cnt);
            if (vecs[v].ia >= 0) chk("table_pix_a", got_q[vecs[v].ia], vecs[v].va);
            if (vecs[v].ib >= 0) chk("table_pix_b", got_q[vecs[v].ib], vecs[v].vb);
            if (vecs[v].ic >= 0) chk("table_pix_c", got_q[vecs[v].ic], vecs[v].vc);
        end

        // Latency, hold under backpressure, and handshake plus reload in one cycle
        got_q.delete(); got_last.delete();
        ready_mode = 0;
        edge_drive();
        mode = MODE_BYPASS; start = 1'b1;
        sample();
        edge_drive();
        start = 1'b0; s_valid = 1'b1; s_data = 8'hA5;
        sample();
        chk("lat_s_ready", s_ready, 1);
        edge_drive();
        s_valid = 1'b0;
        sample();
        chk("lat_m_valid", m_valid, 1);
        chk("lat_m_data", m_data, 8'hA5);
        chk("stall_s_ready", s_ready, 0);
        repeat (3) begin
            edge_drive();
            sample();
        end
        chk("hold_m_valid", m_valid, 1);
        chk("hold_m_data", m_data, 8'hA5);
        ready_mode = 1;
        edge_drive();
        s_valid = 1'b1; s_data = 8'h3C;
        sample();
        chk("reload_s_ready", s_ready, 1);
        edge_drive();
        s_valid = 1'b0;
        sample();
        chk("reload_m_valid", m_valid, 1);
        chk("reload_m_data", m_data, 8'h3C);
        chk("reload_taken", got_q.size(), 2);
        chk("reload_first", (got_q.size() > 0) ? got_q[0] : 8'h00, 8'hA5);
        edge_drive();
        resetn = 1'b0;
        sample();
        edge_drive();
        sample();
        check_reset_outputs();
        edge_drive();
        resetn = 1'b1;
        sample();

        // Abort a bypass frame after 300 pixels, then run a full clean frame
        fill_img(0);
        ready_mode = 1;
        done_cnt = 0;
        edge_drive();
        mode = MODE_BYPASS; start = 1'b1;
        sample();
        edge_drive();
        start = 1'b0;
        sample();
        idx = 0;
        cyc = 0;
        while (idx < 300 && cyc < 2000) begin
            edge_drive();
            s_valid = 1'b1;
            s_data  = 8'(img[idx / W][idx % W]);
            sample();
            if (s_valid && s_ready) idx++;
            cyc++;
        end
        chk("abort_accepted", idx, 300);
        edge_drive();
        s_valid = 1'b0; resetn = 1'b0;
        sample();
        edge_drive();
        sample();
        check_reset_outputs();
        edge_drive();
        resetn = 1'b1;
        sample();
        repeat (5) begin
            edge_drive();
            sample();
        end
        chk("abort_no_done", done_cnt, 0);
        build_expected(MODE_BYPASS, 8'h00);
        run_frame(MODE_BYPASS, 8'h00, 1);
        chk("after_abort_count", got_q.size(), 1024);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pixel_stream_proc.md
# pixel_stream_proc

Parametrised successor to the fixed-size pixel processor. It sits between the clock-domain-crossed sensor stream and downstream consumers, and processes one frame of IMG_W×IMG_H pixels per start. Modes are bypass, invert, 3×3 Gaussian filter and binary threshold, which replaces the old unimplemented mode 11. Unlike its predecessor, it honours output backpressure, marks the last output of each frame and reports frame completion.

## Interface
- DATA_W, 8: pixel width in bits
- IMG_W, 32: pixels per row, ≥3
- IMG_H, 32: rows per frame, ≥3
- clk  in  1  clock; all logic on the rising edge
- resetn  in  1  reset, synchronous, active-low
- start  in  1  level; sampled only in IDLE
- mode  in  2  00 bypass, 01 invert, 10 gauss3x3, 11 threshold; latched on start
- thresh  in  DATA_W  threshold value; latched on start
- s_valid  in  1  input pixel valid
- s_ready  out  1  input pixel accepted when s_valid && s_ready
- s_data  in  DATA_W  input pixel, raster order
- m_valid  out  1  output pixel valid
- m_ready  in  1  downstream ready
- m_data  out  DATA_W  output pixel
- m_last  out  1  qualifies the final output of the frame
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse at frame end

## Operation
- FSM: IDLE → RUN → DRAIN → IDLE.
- IDLE:
  - If start=1, latch mode and thresh, clear row/col counters, go to RUN.
  - Because start is level-sensitive, holding start high runs back-to-back frames.
- RUN:
  - s_ready = !m_valid || m_ready (single output register, no skid).
  - Each accepted pixel advances col; col wraps at IMG_W-1 and increments row.
  - On accepting pixel (IMG_H-1, IMG_W-1), go to DRAIN; s_ready=0 from the next cycle.
- DRAIN: wait until the output register holds no unsent pixel, then pulse done and go to IDLE.
- Pointwise modes produce one output per input, W·H outputs per frame:
  - bypass: out = in.
  - invert: out = ~in.
  - threshold: out = (in ≥ thresh) ? all-ones : 0.
- gauss3x3:
  - Two line buffers plus a 3×3 window register, updated on each accept.
  - Output is produced only for accepts with row≥2 and col≥2. Kernel [1 2 1; 2 4 2; 1 2 1] is centred on (row-1, col-1).
  - Frame yields (IMG_W-2)·(IMG_H-2) outputs, with no padding.
  - Sum is DATA_W+4 bits wide, so there is no overflow. out = sum>>4, truncated.
- m_last is set with the output from the final accepted pixel in every mode.
- mode, thresh and start changes during RUN/DRAIN are ignored.
- Line buffer contents are not reset. Counters guarantee rows are written before they are read.

## Timing
- Reset values: s_ready=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0; FSM enters IDLE.
- Latency: an accept at edge N gives m_valid=1 after edge N (visible in cycle N+1).
- Throughput: one pixel per cycle when m_ready=1.
- m_valid, m_data and m_last are held stable until m_ready=1. m_valid never drops without a handshake.
- Simultaneous output handshake and new accept in one cycle: the register reloads and m_valid stays 1.
- busy rises the cycle after start is seen in IDLE and falls with done.
- done pulses the cycle after the m_last handshake completes.
- resetn low mid-frame: all outputs return to reset values next edge. The partial frame is discarded and no done is issued.

## Structure
- Package pixel_proc_pkg:
  - Mode encodings MODE_BYPASS, MODE_INVERT, MODE_GAUSS, MODE_THRESH.
  - FSM state enum.
  - Kernel shift constant (4).
- Sub-module line_buffer: IMG_W-deep, DATA_W-wide single-row delay with write enable and no reset. Instantiated twice.

## Test plan
- Bypass, 32×32 ramp in (pixel = index mod 256), m_ready=1:
  - 1024 outputs equal to input.
  - m_last only on output 1024.
  - One done pulse.
- Invert, same ramp: output[i] = 8'hFF - (i mod 256). Then mode 11, thresh=8'h80: outputs 00 for i mod 256 < 128, FF otherwise.
- Gauss, constant frame 8'h40: exactly 900 outputs, all 8'h40.
- Gauss impulse, 8'hFF at (5,5) and 0 elsewhere:
  - Output centred at (5,5) = 8'h3F.
  - Edge neighbours 8'h1F, diagonals 8'h0F.
  - All others 00.
- Random m_ready (50%) in bypass:
  - Output sequence identical to the m_ready=1 run.
  - No pixel lost or duplicated.
  - m_data stable while m_valid && !m_ready.
- resetn low after 300 pixels, then new bypass frame:
  - Outputs reset immediately; no done for the aborted frame.
  - The new frame is a full 1024 correct outputs.
